// File: rtl/car_motion_ctrl_pkg.sv
// Shared types and helpers for the car motion controller: FSM encoding,
// displacement width and the clamp limits that keep the car box on screen.
package car_motion_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        UPDATE    = 2'd1,
        ISSUE     = 2'd2,
        WAIT_DONE = 2'd3
    } motion_state_t;

    localparam int DISP_W = 12;

    // Limit of the box offset from screen centre along one axis; the max is
    // written asymmetrically so odd box/screen sizes still fit exactly.
    function automatic int clamp_limit(input int full, input int box, input bit upper);
        if (upper) begin
            return full - box - (full / 2 - box / 2);
        end
        return box / 2 - full / 2;
    endfunction

endpackage

// File: rtl/car_motion_ctrl_btn_conditioner.sv
// One raw button: 2-FF synchroniser followed by a run-length debounce.
// The accepted level follows the synced level after DEB_CYCLES disagreeing cycles.
module btn_conditioner #(
    parameter int DEB_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level
);

    logic sync1;
    logic sync2;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    generate
        if (DEB_CYCLES == 0) begin : g_bypass
            assign level = sync2;
        end else begin : g_debounce
            localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
            localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

            logic [CNT_W-1:0] cnt;
            logic             level_q;

            // cnt measures how long sync2 has disagreed with the accepted level;
            // any bounce back to the accepted level restarts the run.
            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt     <= '0;
                    level_q <= 1'b0;
                end else if (sync2 == level_q) begin
                    cnt <= '0;
                end else if (cnt == CNT_LAST) begin
                    level_q <= sync2;
                    cnt     <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end

            assign level = level_q;
        end
    endgenerate

endmodule

// File: rtl/car_motion_ctrl.sv
// Per-frame car displacement update with on-screen clamping and renderer
// start/busy/done sequencing; FSM state and pending flag are exported for debug.
module car_motion_ctrl
    import car_motion_ctrl_pkg::*;
#(
    parameter int W              = 320,
    parameter int H              = 240,
    parameter int WB             = 88,
    parameter int HB             = 44,
    parameter int STEP           = 2,
    parameter int DEB_CYCLES     = 250000,
    parameter int TIMEOUT_CYCLES = 262144,
    parameter int DROP_W         = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     frame_tick,
    input  logic                     btn_left,
    input  logic                     btn_right,
    input  logic                     btn_up,
    input  logic                     btn_down,
    input  logic                     btn_center,
    input  logic                     r_busy,
    input  logic                     r_done,
    output logic                     start,
    output logic signed [DISP_W-1:0] dx,
    output logic signed [DISP_W-1:0] dy,
    output logic [DROP_W-1:0]        drop_cnt,
    output logic                     timeout_err,
    output motion_state_t            dbg_state,
    output logic                     dbg_pending
);

    localparam logic signed [DISP_W:0] DX_MIN = (DISP_W+1)'(clamp_limit(W, WB, 1'b0));
    localparam logic signed [DISP_W:0] DX_MAX = (DISP_W+1)'(clamp_limit(W, WB, 1'b1));
    localparam logic signed [DISP_W:0] DY_MIN = (DISP_W+1)'(clamp_limit(H, HB, 1'b0));
    localparam logic signed [DISP_W:0] DY_MAX = (DISP_W+1)'(clamp_limit(H, HB, 1'b1));
    localparam logic signed [DISP_W:0] STEP_X = (DISP_W+1)'(STEP);
    localparam int WD_LAST_I = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam int WD_W      = (WD_LAST_I > 0) ? $clog2(WD_LAST_I + 1) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WD_LAST_I);

    // Button index order: left, right, up, down, center.
    logic [4:0] btn_raw;
    logic [4:0] btn_lvl;
    assign btn_raw = {btn_center, btn_down, btn_up, btn_right, btn_left};

    for (genvar i = 0; i < 5; i++) begin : g_btn
        btn_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_btn (
            .clk   (clk),
            .rst   (rst),
            .raw   (btn_raw[i]),
            .level (btn_lvl[i])
        );
    end

    motion_state_t             state_q, state_d;
    logic                      pending_q, pending_d;
    logic signed [DISP_W-1:0]  dx_q, dx_d, dy_q, dy_d;
    logic [DROP_W-1:0]         drop_q, drop_d;
    logic                      tmo_q, tmo_d;
    logic [WD_W-1:0]           wd_q, wd_d;
    logic signed [DISP_W:0]    dx_nx, dy_nx;

    function automatic logic signed [DISP_W:0] clamp(input logic signed [DISP_W:0] v,
                                                     input logic signed [DISP_W:0] lo,
                                                     input logic signed [DISP_W:0] hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    // Handshake: start is a one-cycle request, only issued from ISSUE while
    // r_busy is low; the request completes on the r_done pulse (or watchdog).
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        dx_d      = dx_q;
        dy_d      = dy_q;
        drop_d    = drop_q;
        tmo_d     = tmo_q;
        wd_d      = '0;
        start     = 1'b0;

        dx_nx = {dx_q[DISP_W-1], dx_q};
        dy_nx = {dy_q[DISP_W-1], dy_q};
        if (btn_lvl[4]) begin
            dx_nx = '0;
            dy_nx = '0;
        end else begin
            if (btn_lvl[0] && !btn_lvl[1]) dx_nx = dx_nx - STEP_X;
            if (btn_lvl[1] && !btn_lvl[0]) dx_nx = dx_nx + STEP_X;
            if (btn_lvl[2] && !btn_lvl[3]) dy_nx = dy_nx - STEP_X;
            if (btn_lvl[3] && !btn_lvl[2]) dy_nx = dy_nx + STEP_X;
        end
        dx_nx = clamp(dx_nx, DX_MIN, DX_MAX);
        dy_nx = clamp(dy_nx, DY_MIN, DY_MAX);

        case (state_q)
            IDLE: begin
                if (frame_tick || pending_q) begin
                    state_d   = UPDATE;
                    pending_d = 1'b0;
                end
            end
            UPDATE: begin
                dx_d    = dx_nx[DISP_W-1:0];
                dy_d    = dy_nx[DISP_W-1:0];
                state_d = ISSUE;
            end
            ISSUE: begin
                if (!r_busy) begin
                    start   = 1'b1;
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (r_done) begin
                    state_d = IDLE;
                end else if (TIMEOUT_CYCLES > 0 && wd_q == WD_LAST) begin
                    tmo_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // A tick in IDLE is consumed by the transition; elsewhere it is queued once.
        if (frame_tick && state_q != IDLE) begin
            if (!pending_q) begin
                pending_d = 1'b1;
            end else if (drop_q != '1) begin
                drop_d = drop_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pending_q <= 1'b0;
            dx_q      <= '0;
            dy_q      <= '0;
            drop_q    <= '0;
            tmo_q     <= 1'b0;
            wd_q      <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            dx_q      <= dx_d;
            dy_q      <= dy_d;
            drop_q    <= drop_d;
            tmo_q     <= tmo_d;
            wd_q      <= wd_d;
        end
    end

    assign dx          = dx_q;
    assign dy          = dy_q;
    assign drop_cnt    = drop_q;
    assign timeout_err = tmo_q;
    assign dbg_state   = state_q;
    assign dbg_pending = pending_q;

endmodule

// File: tb/tb_car_motion_ctrl.sv
// Directed bench for car_motion_ctrl: dut_a has no watchdog, dut_b a 16-cycle
// watchdog; both share stimulus and a renderer model answering dut_a's start.
module tb_car_motion_ctrl;
    import car_motion_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic frame_tick = 1'b0;
    logic btn_left = 1'b0, btn_right = 1'b0, btn_up = 1'b0, btn_down = 1'b0, btn_center = 1'b0;
    logic r_busy = 1'b0;
    logic auto_done = 1'b0;
    logic auto_pulse = 1'b0;
    logic manual_done = 1'b0;
    logic r_done;
    assign r_done = auto_pulse | manual_done;

    logic              start_a, start_b;
    logic signed [11:0] dx_a, dy_a, dx_b, dy_b;
    logic [7:0]        drop_a, drop_b;
    logic              tmo_a, tmo_b;
    motion_state_t     st_a, st_b;
    logic              pend_a, pend_b;

    int tests_run    = 0;
    int tests_failed = 0;
    int start_cnt_a  = 0;
    int start_cnt_b  = 0;
    logic signed [11:0] exp_q[$];

    always #5 clk = ~clk;

    car_motion_ctrl #(.DEB_CYCLES(4), .TIMEOUT_CYCLES(0)) dut_a (
        .clk(clk), .rst(rst), .frame_tick(frame_tick),
        .btn_left(btn_left), .btn_right(btn_right), .btn_up(btn_up),
        .btn_down(btn_down), .btn_center(btn_center),
        .r_busy(r_busy), .r_done(r_done), .start(start_a),
        .dx(dx_a), .dy(dy_a), .drop_cnt(drop_a), .timeout_err(tmo_a),
        .dbg_state(st_a), .dbg_pending(pend_a)
    );

    car_motion_ctrl #(.DEB_CYCLES(4), .TIMEOUT_CYCLES(16)) dut_b (
        .clk(clk), .rst(rst), .frame_tick(frame_tick),
        .btn_left(btn_left), .btn_right(btn_right), .btn_up(btn_up),
        .btn_down(btn_down), .btn_center(btn_center),
        .r_busy(r_busy), .r_done(r_done), .start(start_b),
        .dx(dx_b), .dy(dy_b), .drop_cnt(drop_b), .timeout_err(tmo_b),
        .dbg_state(st_b), .dbg_pending(pend_b)
    );

    task automatic check(input string tag, input int got, input int exp);
        tests_run++;
        if (got != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic step_n(input int n);
        repeat (n) step();
    endtask

    task automatic wait_idle(input string tag, input int max_cycles);
        int n = 0;
        while (st_a != IDLE && n < max_cycles) begin
            step();
            n++;
        end
        check({tag, "_idle"}, int'(st_a), int'(IDLE));
    endtask

    // Tick, then expect UPDATE, a start exactly two cycles later, the new
    // displacement, completion and exactly one start pulse for the frame.
    task automatic run_frame(input string tag, input int exp_dx, input int exp_dy);
        int s0;
        s0 = start_cnt_a;
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        check({tag, "_st_upd"}, int'(st_a), int'(UPDATE));
        check({tag, "_start_early"}, int'(start_a), 0);
        step();
        check({tag, "_start"}, int'(start_a), 1);
        check({tag, "_dx"}, int'(dx_a), exp_dx);
        check({tag, "_dy"}, int'(dy_a), exp_dy);
        wait_idle(tag, 40);
        check({tag, "_nstart"}, start_cnt_a - s0, 1);
    endtask

    // Renderer model: r_done pulse 10 cycles after each start of dut_a.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (auto_done && start_a) begin
                repeat (10) @(posedge clk);
                #2;
                auto_pulse = 1'b1;
                @(posedge clk);
                #2;
                auto_pulse = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (start_a) start_cnt_a++;
            if (start_b) start_cnt_b++;
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "time limit reached");
    end

    initial begin
        int e;
        int s0;

        // Reset values
        step_n(3);
        check("rst_start", int'(start_a), 0);
        check("rst_dx", int'(dx_a), 0);
        check("rst_dy", int'(dy_a), 0);
        check("rst_drop", int'(drop_a), 0);
        check("rst_tmo", int'(tmo_a), 0);
        check("rst_state", int'(st_a), int'(IDLE));
        check("rst_pending", int'(pend_a), 0);
        rst = 1'b0;
        step();

        // Right held: dx = 2, 4, 6
        auto_done = 1'b1;
        btn_right = 1'b1;
        step_n(10);
        for (int k = 1; k <= 3; k++) exp_q.push_back(12'(2 * k));
        while (exp_q.size() > 0) begin
            e = int'(exp_q.pop_front());
            run_frame("right", e, 0);
        end

        // Left held for 70 frames: saturate at -116
        btn_right = 1'b0;
        btn_left  = 1'b1;
        step_n(10);
        e = 6;
        for (int k = 0; k < 70; k++) begin
            e = (e - 2 < -116) ? -116 : e - 2;
            run_frame("left_sat", e, 0);
        end
        check("left_floor", int'(dx_a), -116);

        // Up and down together: no vertical motion
        btn_left = 1'b0;
        btn_up   = 1'b1;
        btn_down = 1'b1;
        step_n(10);
        run_frame("updown", -116, 0);

        // Move to dx=40, dy=-20, then recenter while right is still held
        btn_down = 1'b0;
        step_n(10);
        for (int k = 1; k <= 10; k++) run_frame("up", -116, -2 * k);
        btn_up    = 1'b0;
        btn_right = 1'b1;
        step_n(10);
        for (int k = 1; k <= 78; k++) run_frame("right_back", -116 + 2 * k, -20);
        check("pre_center_dx", int'(dx_a), 40);
        check("pre_center_dy", int'(dy_a), -20);
        btn_center = 1'b1;
        step_n(10);
        run_frame("center", 0, 0);
        btn_center = 1'b0;
        btn_right  = 1'b0;
        step_n(10);

        // Renderer stalls for ~1000 cycles; three ticks arrive meanwhile
        auto_done  = 1'b0;
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        step();
        check("stall_start", int'(start_a), 1);
        step();
        check("stall_wait", int'(st_a), int'(WAIT_DONE));
        for (int k = 0; k < 3; k++) begin
            step_n(300);
            frame_tick = 1'b1;
            step();
            frame_tick = 1'b0;
        end
        step_n(100);
        check("stall_pending", int'(pend_a), 1);
        check("stall_drop", int'(drop_a), 2);
        check("stall_still_wait", int'(st_a), int'(WAIT_DONE));
        check("stall_no_tmo", int'(tmo_a), 0);
        s0 = start_cnt_a;
        manual_done = 1'b1;
        step();
        manual_done = 1'b0;
        check("resume_idle", int'(st_a), int'(IDLE));
        step();
        check("resume_update", int'(st_a), int'(UPDATE));
        check("resume_pend_clr", int'(pend_a), 0);
        step_n(48);
        check("resume_one_start", start_cnt_a - s0, 1);
        check("resume_wait", int'(st_a), int'(WAIT_DONE));
        check("resume_drop", int'(drop_a), 2);
        manual_done = 1'b1;
        step();
        manual_done = 1'b0;
        step_n(20);
        check("resume_done_idle", int'(st_a), int'(IDLE));
        check("resume_no_extra", start_cnt_a - s0, 1);

        // r_busy holds the request in ISSUE for 5 cycles
        btn_right = 1'b1;
        step_n(10);
        auto_done  = 1'b1;
        r_busy     = 1'b1;
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        step();
        s0 = start_cnt_a;
        for (int k = 0; k < 5; k++) begin
            check("busy_no_start", int'(start_a), 0);
            check("busy_issue", int'(st_a), int'(ISSUE));
            step();
        end
        r_busy = 1'b0;
        #1;
        check("busy_release_start", int'(start_a), 1);
        step();
        check("busy_after_start", int'(start_a), 0);
        check("busy_wait", int'(st_a), int'(WAIT_DONE));
        check("busy_dx", int'(dx_a), 2);
        wait_idle("busy", 40);
        check("busy_one_start", start_cnt_a - s0, 1);

        // Reset in the middle of WAIT_DONE
        auto_done  = 1'b0;
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        step_n(3);
        check("mid_wait", int'(st_a), int'(WAIT_DONE));
        check("mid_dx", int'(dx_a), 4);
        rst = 1'b1;
        step();
        check("mrst_start", int'(start_a), 0);
        check("mrst_dx", int'(dx_a), 0);
        check("mrst_dy", int'(dy_a), 0);
        check("mrst_drop", int'(drop_a), 0);
        check("mrst_tmo", int'(tmo_b), 0);
        check("mrst_state", int'(st_a), int'(IDLE));
        check("mrst_pending", int'(pend_a), 0);
        btn_right = 1'b0;
        step();
        rst = 1'b0;
        step_n(2);

        // r_done coinciding with the watchdog's last cycle wins
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        step();
        check("race_start_b", int'(start_b), 1);
        step();
        step_n(15);
        check("race_wait_b", int'(st_b), int'(WAIT_DONE));
        manual_done = 1'b1;
        step();
        manual_done = 1'b0;
        check("race_no_tmo", int'(tmo_b), 0);
        check("race_idle_b", int'(st_b), int'(IDLE));

        // Watchdog expiry with no r_done
        step_n(2);
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        step();
        step();
        for (int k = 1; k < 16; k++) step();
        check("tmo_wait16", int'(st_b), int'(WAIT_DONE));
        check("tmo_not_yet", int'(tmo_b), 0);
        step();
        check("tmo_set", int'(tmo_b), 1);
        check("tmo_idle", int'(st_b), int'(IDLE));
        check("tmo_a_off", int'(tmo_a), 0);
        s0 = start_cnt_b;
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        step();
        check("tmo_next_start", int'(start_b), 1);
        step();
        check("tmo_sticky", int'(tmo_b), 1);
        check("tmo_one_start", start_cnt_b - s0, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
